// File: rtl/exec_control.sv
// Execution sequencer: turns RUN/STEP/HALT debug commands into the processor clock enable
// and reports how many cycles were enabled when each operation finishes.
module exec_control #(
    parameter int NBITS = 32,
    parameter int CMDW  = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_cmd_valid,
    input  logic [CMDW-1:0]  i_cmd,
    input  logic [NBITS-1:0] i_step_count,
    input  logic             i_halt,
    output logic             o_enable,
    output logic             o_cmd_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_halted,
    output logic [NBITS-1:0] o_cycles
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_DONE} state_t;

    localparam logic [CMDW-1:0] CMD_HALT = CMDW'(0);
    localparam logic [CMDW-1:0] CMD_RUN  = CMDW'(1);
    localparam logic [CMDW-1:0] CMD_STEP = CMDW'(2);

    state_t           state_q, state_d;
    logic [NBITS-1:0] cnt_q, cnt_d;
    logic [NBITS-1:0] rem_q, rem_d;
    logic [NBITS-1:0] cycles_q, cycles_d;
    logic             halted_q, halted_d;
    logic             enable_q, enable_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             stop;
    logic             start_req;

    // Either stop source ends RUN/STEP; the cycle in which it is seen still counts.
    assign stop      = i_halt | (i_cmd_valid & (i_cmd == CMD_HALT));
    assign start_req = i_cmd_valid & ((i_cmd == CMD_RUN) | (i_cmd == CMD_STEP));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        cycles_d = cycles_q;
        halted_d = halted_q | i_halt;
        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    if (halted_q || (i_cmd == CMD_STEP && i_step_count == '0)) begin
                        state_d  = S_DONE;
                        cycles_d = '0;
                    end else if (i_cmd == CMD_RUN) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_STEP;
                        cnt_d   = '0;
                        rem_d   = i_step_count;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + NBITS'(1);
                if (stop) begin
                    state_d  = S_DONE;
                    cycles_d = cnt_q + NBITS'(1);
                end
            end
            S_STEP: begin
                cnt_d = cnt_q + NBITS'(1);
                if (stop || rem_q == NBITS'(1)) begin
                    state_d  = S_DONE;
                    cycles_d = cnt_q + NBITS'(1);
                end else begin
                    rem_d = rem_q - NBITS'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        enable_d = (state_d == S_RUN) || (state_d == S_STEP);
        done_d   = (state_d == S_DONE);
        ready_d  = (state_d == S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            cycles_q <= '0;
            halted_q <= 1'b0;
            enable_q <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            cycles_q <= cycles_d;
            halted_q <= halted_d;
            enable_q <= enable_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign o_enable    = enable_q;
    assign o_busy      = enable_q;
    assign o_done      = done_q;
    assign o_cmd_ready = ready_q;
    assign o_halted    = halted_q;
    assign o_cycles    = cycles_q;

endmodule

// File: doc/exec_control.md
Name: exec_control

Overview:
Execution sequencer on the command side of the clock-control unit. It accepts RUN / STEP / HALT commands from the debug unit and generates the `enable` level that gates the processor clock. It stops on command, on step exhaustion, or on the CPU halt flag. At the end of every operation it reports the number of enabled cycles.

Parameters:
- NBITS, 32, width of the step-count operand and of the cycle counter/report.
- CMDW, 2, command code width (0 = HALT, 1 = RUN, 2 = STEP, 3 = reserved).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_cmd_valid  in  1  command strobe, one cycle.
- i_cmd  in  CMDW  command code, sampled with i_cmd_valid.
- i_step_count  in  NBITS  cycles to execute for STEP, sampled with i_cmd_valid.
- i_halt  in  1  CPU end-of-program flag (level).
- o_enable  out  1  drives the clock-control enable input; registered.
- o_cmd_ready  out  1  high when a RUN/STEP command will be accepted.
- o_busy  out  1  high in RUN or STEP.
- o_done  out  1  one-cycle pulse when an operation ends.
- o_halted  out  1  sticky: CPU halt has been seen.
- o_cycles  out  NBITS  enabled-cycle count of the last finished operation.

Behaviour:
- Reset:
  - State IDLE.
  - o_enable = 0, o_busy = 0, o_done = 0, o_halted = 0, o_cycles = 0.
  - Internal counters = 0.
  - o_cmd_ready = 1 in the cycle after reset deasserts.
  - Reset mid-RUN/STEP aborts immediately: o_enable = 0 on the next edge, no o_done.
- States: IDLE, RUN, STEP, DONE. All outputs are registered or decoded from state.
  - o_enable = 1 only in RUN and STEP.
  - o_busy = o_enable.
  - o_done = 1 only in DONE.
  - o_cmd_ready = 1 only in IDLE.
- IDLE:
  - RUN accepted (cmd_valid, cmd = 1, o_halted = 0) at edge t: clear op counter; go to RUN. o_enable = 1 from cycle t+1.
  - STEP accepted with i_step_count = N > 0 and o_halted = 0: load remaining = N; go to STEP.
  - STEP with N = 0: go to DONE with o_cycles = 0.
  - RUN/STEP while o_halted = 1: rejected; go to DONE with o_cycles = 0.
  - HALT and reserved codes: ignored.
- RUN:
  - Op counter increments every cycle.
  - Exit to DONE on the edge where i_halt = 1 or a HALT command is valid; both in the same cycle are equivalent.
  - The cycle in which the stop is sampled is counted.
  - RUN/STEP commands while in RUN are ignored.
- STEP:
  - Op counter increments every cycle.
  - If remaining = 1, next state is DONE; otherwise remaining decrements.
  - Early exit to DONE on i_halt = 1 or a HALT command; the current cycle is counted.
  - Result: exactly N enabled cycles unless stopped early.
- DONE (one cycle):
  - o_done = 1, o_enable = 0.
  - o_cycles latched from the op counter on the transition into DONE, and held until the next DONE.
  - Returns to IDLE unconditionally; commands in DONE are ignored.
- o_halted:
  - Set on any edge where i_halt = 1, in any state.
  - Cleared only by reset.
- Arithmetic:
  - Op counter and remaining are NBITS wide, unsigned.
  - Op counter wraps to 0 after 2^NBITS−1; no saturation.

Test Plan:
- Reset, then idle 3 cycles → o_enable = 0, o_cmd_ready = 1, o_cycles = 0, o_done never high.
- STEP N = 3 accepted at edge t → o_enable high in cycles t+1..t+3, o_done high at t+4, o_cycles = 3, o_cmd_ready = 1 at t+5.
- RUN at t, HALT command at t+8 → o_enable high t+1..t+8, o_done at t+9, o_cycles = 8, o_halted = 0.
- RUN at t, i_halt pulsed at t+5 → o_done at t+6, o_cycles = 5, o_halted = 1. A subsequent STEP N = 4 produces o_done the cycle after acceptance, o_cycles = 0, o_enable never high.
- STEP N = 0 → no enable cycles, o_done next cycle, o_cycles = 0. STEP N = 10 with i_halt at the 4th enabled cycle → o_cycles = 4.
- RUN at t, reset asserted at t+3 → o_enable = 0 at t+4, no o_done, o_cycles = 0. Then STEP N = 1 → exactly one enable cycle, o_cycles = 1.
